// File: rtl/yes_sprite_blitter_if.sv
// Pixel-stream / sprite-ROM / control bundle for yes_sprite_blitter.
// master: video timing + ROM side driver; slave: the blitter itself.
interface yes_sprite_blitter_if;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        video_on;
   logic        frame_tick;
   logic        show;
   logic [9:0]  origin_x;
   logic [9:0]  origin_y;
   logic [11:0] bg_rgb;
   logic [4:0]  rom_row;
   logic [5:0]  rom_col;
   logic [11:0] rom_data;
   logic [11:0] rgb_out;
   logic        video_on_o;
   logic        sprite_on;
   logic        busy;

   modport master (
      output x, y, video_on, frame_tick, show,
      output origin_x, origin_y, bg_rgb, rom_data,
      input  rom_row, rom_col, rgb_out,
      input  video_on_o, sprite_on, busy
   );

   modport slave (
      input  x, y, video_on, frame_tick, show,
      input  origin_x, origin_y, bg_rgb, rom_data,
      output rom_row, rom_col, rgb_out,
      output video_on_o, sprite_on, busy
   );
endinterface

// File: rtl/yes_sprite_blitter.sv
// Sprite blitter: composites a 64x32 ROM sprite over the background
// pixel stream at a frame-latched origin, with show/blink/hide FSM.
// Ports: clk, reset (async, active-high), bus (yes_sprite_blitter_if.slave):
//   in  x, y, video_on, frame_tick, show, origin_x, origin_y, bg_rgb, rom_data
//   out rom_row, rom_col (comb), rgb_out, video_on_o, sprite_on (2-clk), busy
// Option: YES_SPRITE_SCALE2X_EN draws the sprite at 2x (window doubled).
module yes_sprite_blitter #(
   parameter int          SPR_W        = 64,
   parameter int          SPR_H        = 32,
   parameter int          SHOW_FRAMES  = 120,
   parameter int          BLINK_FRAMES = 64,
   parameter int          BLINK_HALF   = 8,
   parameter logic [11:0] KEY_COLOR    = 12'h000
) (
   input logic                  clk,
   input logic                  reset,
   yes_sprite_blitter_if.slave  bus
);

`ifdef YES_SPRITE_SCALE2X_EN
   localparam int SCALE = 2;
`else
   localparam int SCALE = 1;
`endif
   localparam int WIN_W     = SPR_W * SCALE;
   localparam int WIN_H     = SPR_H * SCALE;
   localparam int BLINK_BIT = $clog2(BLINK_HALF);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHOW,
      ST_BLINK
   } state_t;

   state_t      r_state;
   state_t      w_state_nx;
   logic [7:0]  r_fcnt;
   logic [7:0]  w_fcnt_nx;
   logic        w_visible;
   logic        w_busy;

   logic [9:0]  r_org_x;
   logic [9:0]  r_org_y;

   logic [10:0] w_x;
   logic [10:0] w_y;
   logic [10:0] w_ox;
   logic [10:0] w_oy;
   logic        w_hit;
   logic [5:0]  w_col;
   logic [4:0]  w_row;

   logic        r_s1_hit;
   logic        r_s1_video;
   logic [11:0] r_s1_bg;
   logic        w_opaque;

   logic [11:0] r_rgb;
   logic        r_sprite_on;
   logic        r_video_o;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_fcnt  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_fcnt  <= w_fcnt_nx;
      end
   end

   // ---------------- FSM: next state ----------------
   // show has priority over frame_tick so a restart always lands at fcnt=0.
   always_comb begin
      w_state_nx = r_state;
      w_fcnt_nx  = r_fcnt;
      if (bus.show) begin
         w_state_nx = ST_SHOW;
         w_fcnt_nx  = '0;
      end else if (bus.frame_tick) begin
         unique case (r_state)
            ST_SHOW: begin
               if (r_fcnt == 8'(SHOW_FRAMES - 1)) begin
                  w_state_nx = ST_BLINK;
                  w_fcnt_nx  = '0;
               end else begin
                  w_fcnt_nx  = r_fcnt + 8'd1;
               end
            end
            ST_BLINK: begin
               if (r_fcnt == 8'(BLINK_FRAMES - 1)) begin
                  w_state_nx = ST_IDLE;
                  w_fcnt_nx  = '0;
               end else begin
                  w_fcnt_nx  = r_fcnt + 8'd1;
               end
            end
            default: begin
               w_state_nx = r_state;
               w_fcnt_nx  = r_fcnt;
            end
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   // Blink phase starts "on" because fcnt restarts at 0 on entry.
   always_comb begin
      w_visible = 1'b0;
      w_busy    = 1'b0;
      unique case (r_state)
         ST_SHOW: begin
            w_visible = 1'b1;
            w_busy    = 1'b1;
         end
         ST_BLINK: begin
            w_visible = ~r_fcnt[BLINK_BIT];
            w_busy    = 1'b1;
         end
         default: begin
            w_visible = 1'b0;
            w_busy    = 1'b0;
         end
      endcase
   end

   // Origin latched once per frame so a moving sprite never tears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_org_x <= '0;
         r_org_y <= '0;
      end else if (bus.frame_tick) begin
         r_org_x <= bus.origin_x;
         r_org_y <= bus.origin_y;
      end
   end

   // 11-bit compare: a window near 1023 must not wrap onto column 0.
   assign w_x  = {1'b0, bus.x};
   assign w_y  = {1'b0, bus.y};
   assign w_ox = {1'b0, r_org_x};
   assign w_oy = {1'b0, r_org_y};

   assign w_hit = (w_x >= w_ox) && (w_x < w_ox + 11'(WIN_W)) &&
                  (w_y >= w_oy) && (w_y < w_oy + 11'(WIN_H));

`ifdef YES_SPRITE_SCALE2X_EN
   assign w_col = 6'((bus.x - r_org_x) >> 1);
   assign w_row = 5'((bus.y - r_org_y) >> 1);
`else
   assign w_col = 6'(bus.x - r_org_x);
   assign w_row = 5'(bus.y - r_org_y);
`endif

   assign bus.rom_col = w_hit ? w_col : 6'd0;
   assign bus.rom_row = w_hit ? w_row : 5'd0;

   // Stage 1: aligns control with the ROM's one-clock read latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_hit   <= 1'b0;
         r_s1_video <= 1'b0;
         r_s1_bg    <= '0;
      end else begin
         r_s1_hit   <= w_hit & bus.video_on & w_visible;
         r_s1_video <= bus.video_on;
         r_s1_bg    <= bus.bg_rgb;
      end
   end

   assign w_opaque = r_s1_hit && (bus.rom_data != KEY_COLOR);

   // Stage 2: composite.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rgb       <= '0;
         r_sprite_on <= 1'b0;
         r_video_o   <= 1'b0;
      end else begin
         r_rgb       <= w_opaque   ? bus.rom_data :
                        r_s1_video ? r_s1_bg      : 12'h000;
         r_sprite_on <= w_opaque;
         r_video_o   <= r_s1_video;
      end
   end

   assign bus.rgb_out    = r_rgb;
   assign bus.sprite_on  = r_sprite_on;
   assign bus.video_on_o = r_video_o;
   assign bus.busy       = w_busy;

endmodule

// File: tb/tb_yes_sprite_blitter.sv
// Randomized bench for yes_sprite_blitter against a frame-count model.
// Define YES_SPRITE_SCALE2X_EN for both DUT and bench to cover 2x mode.
module tb_yes_sprite_blitter;

`ifdef YES_SPRITE_SCALE2X_EN
   localparam int SC = 2;
`else
   localparam int SC = 1;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   yes_sprite_blitter_if bus ();

   yes_sprite_blitter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [11:0] rom [0:2047];

   // model: origin, "frames since show" and whether a sequence is live
   int m_ox, m_oy;
   bit m_act;
   int m_n;

   bit          pv_valid;
   logic [11:0] pv_rgb;
   bit          pv_spr;
   bit          pv_vid;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   // 120 solid frames, then 64 frames toggling every 8 starting on.
   function automatic bit m_visible();
      if (!m_act)     return 1'b0;
      if (m_n < 120)  return 1'b1;
      return (((m_n - 120) / 8) % 2) == 0;
   endfunction

   task automatic cycle(input int x, input int y, input bit vid,
                        input bit ft, input bit sh,
                        input int ox, input int oy,
                        input logic [11:0] bg);
      bit          hit;
      int          col, row;
      bit          e_spr;
      logic [11:0] c, e_rgb;
      bus.x          = 10'(x);
      bus.y          = 10'(y);
      bus.video_on   = vid;
      bus.frame_tick = ft;
      bus.show       = sh;
      bus.origin_x   = 10'(ox);
      bus.origin_y   = 10'(oy);
      bus.bg_rgb     = bg;
      #1;
      hit = (x >= m_ox) && (x < m_ox + SC * 64) &&
            (y >= m_oy) && (y < m_oy + SC * 32);
      col = hit ? (x - m_ox) / SC : 0;
      row = hit ? (y - m_oy) / SC : 0;
      check("rom_col", 32'(bus.rom_col), 32'(col));
      check("rom_row", 32'(bus.rom_row), 32'(row));
      check("busy", 32'(bus.busy), 32'(m_act));
      c     = rom[row * 64 + col];
      e_spr = hit && vid && m_visible() && (c != 12'h000);
      e_rgb = e_spr ? c : (vid ? bg : 12'h000);
      @(posedge clk);
      #1;
      bus.rom_data = c;
      if (pv_valid) begin
         check("rgb_out", 32'(bus.rgb_out), 32'(pv_rgb));
         check("sprite_on", 32'(bus.sprite_on), 32'(pv_spr));
         check("video_on_o", 32'(bus.video_on_o), 32'(pv_vid));
      end
      pv_valid = 1'b1;
      pv_rgb   = e_rgb;
      pv_spr   = e_spr;
      pv_vid   = vid;
      if (ft) begin
         m_ox = ox;
         m_oy = oy;
      end
      if (sh) begin
         m_act = 1'b1;
         m_n   = 0;
      end else if (ft && m_act) begin
         m_n++;
         if (m_n == 184) begin
            m_act = 1'b0;
            m_n   = 0;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      check("rst_rgb", 32'(bus.rgb_out), 32'h0);
      check("rst_spr", 32'(bus.sprite_on), 32'h0);
      check("rst_vid", 32'(bus.video_on_o), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      m_ox     = 0;
      m_oy     = 0;
      m_act    = 1'b0;
      m_n      = 0;
      // flushed pipeline must emit zeros on the first edge
      pv_valid = 1'b1;
      pv_rgb   = '0;
      pv_spr   = 1'b0;
      pv_vid   = 1'b0;
   endtask

   task automatic rand_cycle(input int ft_mod, input int sh_mod);
      int x, y;
      x = (m_ox + $urandom_range(0, SC * 64 + 8) - 4) & 1023;
      y = (m_oy + $urandom_range(0, SC * 32 + 8) - 4) & 1023;
      cycle(x, y, $urandom_range(0, 7) != 0,
            $urandom_range(0, ft_mod - 1) == 0,
            sh_mod > 0 && $urandom_range(0, sh_mod - 1) == 0,
            $urandom_range(0, 1023), $urandom_range(0, 1023),
            12'($urandom));
   endtask

   initial begin
      reset        = 1'b1;
      bus.x        = '0;
      bus.y        = '0;
      bus.video_on = 1'b0;
      bus.frame_tick = 1'b0;
      bus.show     = 1'b0;
      bus.origin_x = '0;
      bus.origin_y = '0;
      bus.bg_rgb   = '0;
      bus.rom_data = '0;
      for (int i = 0; i < 2048; i++)
         rom[i] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
      pv_valid = 1'b0;
      #2;
      do_reset();

      // idle: background passes through, sprite never drawn
      for (int i = 0; i < 20; i++) rand_cycle(4, 0);

      // origin (100,50), then show
      cycle(0, 0, 1'b1, 1'b1, 1'b0, 100, 50, 12'h123);
      cycle(0, 0, 1'b1, 1'b0, 1'b1, 100, 50, 12'h123);
      rom[0] = 12'hCF7;
      cycle(100, 50, 1'b1, 1'b0, 1'b0, 0, 0, 12'h00F);
      cycle(0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 12'h00F);
      check("t2_rgb", 32'(bus.rgb_out), 32'hCF7);
      check("t2_spr", 32'(bus.sprite_on), 32'h1);
      rom[0] = 12'h000;
      cycle(100, 50, 1'b1, 1'b0, 1'b0, 0, 0, 12'h00F);
      cycle(100, 50, 1'b0, 1'b0, 1'b0, 0, 0, 12'h00F);
      check("t3_key", 32'(bus.rgb_out), 32'h00F);
      cycle(0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 12'h00F);
      check("t3_blank", 32'(bus.rgb_out), 32'h0);

      // window edges in both axes
      cycle(100 + SC * 64 - 1, 50, 1'b1, 1'b0, 1'b0, 0, 0, 12'h0F0);
      cycle(100 + SC * 64, 50, 1'b1, 1'b0, 1'b0, 0, 0, 12'h0F0);
      cycle(100, 50 + SC * 32 - 1, 1'b1, 1'b0, 1'b0, 0, 0, 12'h0F0);
      cycle(100, 50 + SC * 32, 1'b1, 1'b0, 1'b0, 0, 0, 12'h0F0);
      cycle(99, 49, 1'b1, 1'b0, 1'b0, 0, 0, 12'h0F0);
      // no wrap past column 1023
      cycle(0, 0, 1'b1, 1'b1, 1'b0, 1000, 50, 12'h0F0);
      cycle(5, 50, 1'b1, 1'b0, 1'b0, 0, 0, 12'h0F0);
      cycle(1023, 50, 1'b1, 1'b0, 1'b0, 0, 0, 12'h0F0);
`ifdef YES_SPRITE_SCALE2X_EN
      cycle(0, 0, 1'b1, 1'b1, 1'b0, 0, 0, 12'h0F0);
      cycle(127, 63, 1'b1, 1'b0, 1'b0, 0, 0, 12'h0F0);
      cycle(128, 63, 1'b1, 1'b0, 1'b0, 0, 0, 12'h0F0);
`endif

      // full show/blink/idle sequence with a tick every other clock
      cycle(0, 0, 1'b1, 1'b1, 1'b1, 200, 100, 12'h111);
      for (int i = 0; i < 420; i++)
         cycle(200 + $urandom_range(0, SC * 64 - 1),
               100 + $urandom_range(0, SC * 32 - 1),
               1'b1, i[0], 1'b0, 200, 100, 12'h111);
      check("seq_done", 32'(bus.busy), 32'h0);

      // restart during blink
      cycle(0, 0, 1'b1, 1'b0, 1'b1, 0, 0, 12'h222);
      for (int i = 0; i < 260; i++)
         cycle(200 + $urandom_range(0, SC * 64 - 1),
               100 + $urandom_range(0, SC * 32 - 1),
               1'b1, i[0], (i == 259), 200, 100, 12'h222);
      for (int i = 0; i < 40; i++)
         cycle(200 + $urandom_range(0, SC * 64 - 1),
               100 + $urandom_range(0, SC * 32 - 1),
               1'b1, i[0], 1'b0, 200, 100, 12'h222);

      // random traffic with a reset dropped in mid-sequence
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         rand_cycle(3, 250);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
